// File: rtl/moesi_pkg.sv
// Shared MOESI encodings: line states, CPU opcodes, bus request types and the
// per-port event set consumed by moesi_next_state.
package moesi_pkg;

   localparam int MOESI_W = 3;

   typedef enum logic [2:0] {
      ST_I = 3'd0,
      ST_S = 3'd1,
      ST_E = 3'd2,
      ST_M = 3'd3,
      ST_O = 3'd4
   } moesi_e;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_FLUSH = 2'b10,
      OP_RSVD  = 2'b11
   } cpu_op_e;

   typedef enum logic [1:0] {
      REQ_RD_MISS   = 2'b00,
      REQ_WR_MISS   = 2'b01,
      REQ_UPGRADE   = 2'b10,
      REQ_WRITEBACK = 2'b11
   } bus_req_e;

   typedef enum logic [2:0] {
      EV_CPU_RD = 3'd0,
      EV_CPU_WR = 3'd1,
      EV_CPU_FL = 3'd2,
      EV_SNP_RD = 3'd3,
      EV_SNP_WR = 3'd4
   } moesi_ev_e;

   // Stored codes 5..7 cannot come from a legal update; treat them as Invalid.
   function automatic moesi_e decode_state(input logic [2:0] raw);
      case (raw)
         3'd1:    return ST_S;
         3'd2:    return ST_E;
         3'd3:    return ST_M;
         3'd4:    return ST_O;
         default: return ST_I;
      endcase
   endfunction

   function automatic moesi_ev_e cpu_event(input logic [1:0] op);
      case (op)
         2'b01:   return EV_CPU_WR;
         2'b10:   return EV_CPU_FL;
         default: return EV_CPU_RD;
      endcase
   endfunction

endpackage

// File: rtl/moesi_next_state.sv
// Combinational MOESI transition for one line: (state, event) -> next state,
// hit/request classification for CPU events, supply/shared for snoop events.
module moesi_next_state
   import moesi_pkg::*;
(
   input  logic [MOESI_W-1:0] state,
   input  moesi_ev_e          ev,
   input  logic               bus_shared,
   output logic [MOESI_W-1:0] next_state,
   output logic               hit,
   output logic               req_valid,
   output logic [1:0]         req_type,
   output logic               supply,
   output logic               shared
);

   moesi_e cur;
   moesi_e nxt;

   always_comb begin
      cur       = decode_state(state);
      nxt       = cur;
      hit       = 1'b0;
      req_valid = 1'b0;
      req_type  = REQ_RD_MISS;
      supply    = (cur == ST_M) || (cur == ST_O);
      shared    = (cur != ST_I);
      case (ev)
         EV_CPU_RD: begin
            if (cur == ST_I) begin
               nxt       = bus_shared ? ST_S : ST_E;
               req_valid = 1'b1;
               req_type  = REQ_RD_MISS;
            end else begin
               hit = 1'b1;
            end
         end
         EV_CPU_WR: begin
            nxt = ST_M;
            case (cur)
               ST_I: begin
                  req_valid = 1'b1;
                  req_type  = REQ_WR_MISS;
               end
               ST_S, ST_O: begin
                  req_valid = 1'b1;
                  req_type  = REQ_UPGRADE;
               end
               default: hit = 1'b1;
            endcase
         end
         EV_CPU_FL: begin
            nxt = ST_I;
            case (cur)
               ST_M, ST_O: begin
                  hit       = 1'b1;
                  req_valid = 1'b1;
                  req_type  = REQ_WRITEBACK;
               end
               ST_S, ST_E: hit = 1'b1;
               default:    hit = 1'b0;
            endcase
         end
         EV_SNP_RD: begin
            if (cur == ST_E) nxt = ST_S;
            else if (cur == ST_M) nxt = ST_O;
         end
         default: nxt = ST_I;
      endcase
      next_state = nxt;
   end

endmodule

// File: rtl/moesi_line_array.sv
// MOESI state array for one private cache: CPU port and snoop port, snoop wins
// on same-line collision. Define MOESI_PERF_EN to add saturating perf counters.
module moesi_line_array
   import moesi_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_WID   = $clog2(NUM_LINES),
   parameter int MOESI_WID = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_valid,
   output logic                 cpu_ready,
   input  logic [1:0]           cpu_op,
   input  logic [IDX_WID-1:0]   cpu_idx,
   input  logic                 bus_shared,
   input  logic                 snp_valid,
   input  logic                 snp_write,
   input  logic [IDX_WID-1:0]   snp_idx,
   output logic                 cpu_rsp_valid,
   output logic                 cpu_rsp_hit,
   output logic [MOESI_WID-1:0] cpu_rsp_state,
   output logic                 bus_req_valid,
   output logic [1:0]           bus_req_type,
   output logic                 snp_rsp_valid,
   output logic                 snp_rsp_supply,
   output logic                 snp_rsp_shared
`ifdef MOESI_PERF_EN
   ,
   output logic [15:0]          perf_hit,
   output logic [15:0]          perf_miss,
   output logic [15:0]          perf_inval
`endif
);

   logic [MOESI_W-1:0] lines [NUM_LINES];

   logic [MOESI_W-1:0] cpu_next;
   logic               cpu_hit;
   logic               cpu_req_valid;
   logic [1:0]         cpu_req_type;
   logic               cpu_unused_supply;
   logic               cpu_unused_shared;

   logic [MOESI_W-1:0] snp_next;
   logic               snp_supply;
   logic               snp_shared;
   logic               snp_unused_hit;
   logic               snp_unused_req_valid;
   logic [1:0]         snp_unused_req_type;

   logic collision;
   logic cpu_accept;

   moesi_next_state u_cpu_ns (
      .state      (lines[cpu_idx]),
      .ev         (cpu_event(cpu_op)),
      .bus_shared (bus_shared),
      .next_state (cpu_next),
      .hit        (cpu_hit),
      .req_valid  (cpu_req_valid),
      .req_type   (cpu_req_type),
      .supply     (cpu_unused_supply),
      .shared     (cpu_unused_shared)
   );

   moesi_next_state u_snp_ns (
      .state      (lines[snp_idx]),
      .ev         (snp_write ? EV_SNP_WR : EV_SNP_RD),
      .bus_shared (1'b0),
      .next_state (snp_next),
      .hit        (snp_unused_hit),
      .req_valid  (snp_unused_req_valid),
      .req_type   (snp_unused_req_type),
      .supply     (snp_supply),
      .shared     (snp_shared)
   );

   // A same-line snoop must land first so the retried CPU access sees its effect.
   assign collision  = cpu_valid && snp_valid && (cpu_idx == snp_idx);
   assign cpu_ready  = reset && !collision;
   assign cpu_accept = cpu_valid && cpu_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_LINES; i++) lines[i] <= ST_I;
         cpu_rsp_valid  <= 1'b0;
         cpu_rsp_hit    <= 1'b0;
         cpu_rsp_state  <= MOESI_WID'(ST_I);
         bus_req_valid  <= 1'b0;
         bus_req_type   <= REQ_RD_MISS;
         snp_rsp_valid  <= 1'b0;
         snp_rsp_supply <= 1'b0;
         snp_rsp_shared <= 1'b0;
      end else begin
         if (snp_valid)  lines[snp_idx] <= snp_next;
         if (cpu_accept) lines[cpu_idx] <= cpu_next;
         cpu_rsp_valid <= cpu_accept;
         cpu_rsp_hit   <= cpu_accept && cpu_hit;
         bus_req_valid <= cpu_accept && cpu_req_valid;
         if (cpu_accept) begin
            cpu_rsp_state <= MOESI_WID'(cpu_next);
            bus_req_type  <= cpu_req_type;
         end
         snp_rsp_valid  <= snp_valid;
         snp_rsp_supply <= snp_valid && snp_supply;
         snp_rsp_shared <= snp_valid && snp_shared;
      end
   end

`ifdef MOESI_PERF_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
   logic [15:0] inval_cnt;

   // Misses and upgrades both cost a bus transaction; writebacks do not count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         inval_cnt <= '0;
      end else begin
         if (cpu_accept && cpu_hit) hit_cnt <= sat_inc(hit_cnt);
         if (cpu_accept && cpu_req_valid && (cpu_req_type != REQ_WRITEBACK))
            miss_cnt <= sat_inc(miss_cnt);
         if (snp_valid && snp_write && snp_shared) inval_cnt <= sat_inc(inval_cnt);
      end
   end

   assign perf_hit   = hit_cnt;
   assign perf_miss  = miss_cnt;
   assign perf_inval = inval_cnt;
`endif

endmodule
